// File: rtl/note_tone_gen_pkg.sv
// Shared definitions for the square-wave tone generator: note codes, the
// octave-0 half-period table for a 50 MHz clock, and the FSM state type.
package synth_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int          NOTE_W = 4;
    localparam int          OCT_W  = 3;

    // Wide enough for the half period of any note down to 16 Hz.
    localparam int                HP_W   = $clog2(CLK_HZ / 32);
    localparam logic [HP_W-1:0]   HP_ONE = HP_W'(1);

    localparam logic [NOTE_W-1:0] NOTE_A     = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_AS    = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_B     = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_C     = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_CS    = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_D     = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_DS    = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_E     = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_F     = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_FS    = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_G     = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_GS    = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_COUNT = 4'd12;
    localparam logic [OCT_W-1:0]  OCT_MAX    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY
    } state_e;

    // round(CLK_HZ / (2 * f)) at octave 0; C..G# sit below A0 in scientific pitch.
    function automatic logic [HP_W-1:0] base_period(input logic [NOTE_W-1:0] note);
        case (note)
            NOTE_A:  base_period = HP_W'(909091);
            NOTE_AS: base_period = HP_W'(858068);
            NOTE_B:  base_period = HP_W'(809908);
            NOTE_C:  base_period = HP_W'(1528903);
            NOTE_CS: base_period = HP_W'(1443092);
            NOTE_D:  base_period = HP_W'(1362097);
            NOTE_DS: base_period = HP_W'(1285649);
            NOTE_E:  base_period = HP_W'(1213491);
            NOTE_F:  base_period = HP_W'(1145383);
            NOTE_FS: base_period = HP_W'(1081097);
            NOTE_G:  base_period = HP_W'(1020420);
            NOTE_GS: base_period = HP_W'(963148);
            default: base_period = '0;
        endcase
    endfunction

    function automatic logic codes_valid(input logic [NOTE_W-1:0] note,
                                         input logic [OCT_W-1:0]  octave);
        return (note < NOTE_COUNT) && (octave <= OCT_MAX);
    endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Note-control and audio-sample bundle between the note controller (master)
// and the tone generator (slave).
interface note_tone_gen_if #(
    parameter int SAMPLE_W = 24
) ();
    import synth_pkg::*;

    logic [NOTE_W-1:0]          note;
    logic [OCT_W-1:0]           octave;
    logic                       note_valid;
    logic                       note_off;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       square;
    logic                       playing;

    modport master (
        output note, octave, note_valid, note_off,
        input  sample, square, playing
    );

    modport slave (
        input  note, octave, note_valid, note_off,
        output sample, square, playing
    );

endinterface

// File: rtl/note_tone_gen_period_rom.sv
// Combinational (note, octave) -> half-period lookup; the octave shift floors.
module tone_period_rom
    import synth_pkg::*;
(
    input  logic [NOTE_W-1:0] note_i,
    input  logic [OCT_W-1:0]  octave_i,
    output logic [HP_W-1:0]   half_period_o,
    output logic              invalid_o
);

    always_comb begin
        invalid_o     = !codes_valid(note_i, octave_i);
        half_period_o = '0;
        if (!invalid_o) begin
            half_period_o = base_period(note_i) >> octave_i;
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: IDLE -> LOAD -> PLAY, with pitch changes and
// stop requests deferred to the next half-period boundary.
module note_tone_gen
    import synth_pkg::*;
#(
    parameter int SAMPLE_W  = 24,
    parameter int AMPLITUDE = 2**20
) (
    input logic            clk,
    input logic            reset,
    note_tone_gen_if.slave bus
);

    localparam logic signed [SAMPLE_W-1:0] AMP_P = SAMPLE_W'(AMPLITUDE);
    localparam logic signed [SAMPLE_W-1:0] AMP_N = -AMP_P;

    state_e             state_q, state_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [OCT_W-1:0]   oct_q, oct_d;
    logic [HP_W-1:0]    cur_hp_q, cur_hp_d;
    logic [HP_W-1:0]    cnt_q, cnt_d;
    logic               square_q, square_d;
    logic               stop_q, stop_d;
    logic               pcap_q, pcap_d;
    logic [NOTE_W-1:0]  pnote_q, pnote_d;
    logic [OCT_W-1:0]   poct_q, poct_d;
    logic               pend_q, pend_d;
    logic [HP_W-1:0]    pend_hp_q, pend_hp_d;

    logic [HP_W-1:0]    cur_rom_hp, pend_rom_hp;
    logic               cur_rom_bad, pend_rom_bad;
    logic               nv_ok, stop_evt;

    tone_period_rom u_cur_rom (
        .note_i        (note_q),
        .octave_i      (oct_q),
        .half_period_o (cur_rom_hp),
        .invalid_o     (cur_rom_bad)
    );

    tone_period_rom u_pend_rom (
        .note_i        (pnote_q),
        .octave_i      (poct_q),
        .half_period_o (pend_rom_hp),
        .invalid_o     (pend_rom_bad)
    );

    // An out-of-range note request behaves exactly like note_off; note_off wins ties.
    assign nv_ok    = bus.note_valid && codes_valid(bus.note, bus.octave);
    assign stop_evt = bus.note_off || (bus.note_valid && !nv_ok);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d   = state_q;
        note_d    = note_q;
        oct_d     = oct_q;
        cur_hp_d  = cur_hp_q;
        cnt_d     = cnt_q;
        square_d  = square_q;
        stop_d    = stop_q;
        pcap_d    = pcap_q;
        pnote_d   = pnote_q;
        poct_d    = poct_q;
        pend_d    = pend_q;
        pend_hp_d = pend_hp_q;

        case (state_q)
            ST_IDLE: begin
                if (!stop_evt && nv_ok) begin
                    note_d  = bus.note;
                    oct_d   = bus.octave;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (stop_evt || cur_rom_bad) begin
                    note_d  = '0;
                    oct_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cur_hp_d = cur_rom_hp;
                    cnt_d    = cur_rom_hp - HP_ONE;
                    square_d = 1'b1;
                    state_d  = ST_PLAY;
                end
            end

            ST_PLAY: begin
                cnt_d = cnt_q - HP_ONE;
                if (cnt_q == '0) begin
                    square_d = !square_q;
                    if (pend_q) begin
                        cur_hp_d = pend_hp_q;
                        cnt_d    = pend_hp_q - HP_ONE;
                        pend_d   = 1'b0;
                    end else begin
                        cnt_d = cur_hp_q - HP_ONE;
                    end
                end

                // Captured codes become an armed period one cycle after capture.
                if (pcap_q && !pend_rom_bad) begin
                    pend_hp_d = pend_rom_hp;
                    pend_d    = 1'b1;
                end
                pcap_d = 1'b0;

                if (stop_evt) begin
                    stop_d = 1'b1;
                end else if (nv_ok) begin
                    pcap_d  = 1'b1;
                    pnote_d = bus.note;
                    poct_d  = bus.octave;
                end

                if (cnt_q == '0 && stop_q) begin
                    state_d   = ST_IDLE;
                    note_d    = '0;
                    oct_d     = '0;
                    cur_hp_d  = '0;
                    cnt_d     = '0;
                    square_d  = 1'b0;
                    stop_d    = 1'b0;
                    pcap_d    = 1'b0;
                    pnote_d   = '0;
                    poct_d    = '0;
                    pend_d    = 1'b0;
                    pend_hp_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            note_q    <= '0;
            oct_q     <= '0;
            cur_hp_q  <= '0;
            cnt_q     <= '0;
            square_q  <= 1'b0;
            stop_q    <= 1'b0;
            pcap_q    <= 1'b0;
            pnote_q   <= '0;
            poct_q    <= '0;
            pend_q    <= 1'b0;
            pend_hp_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q   <= state_d;
            note_q    <= note_d;
            oct_q     <= oct_d;
            cur_hp_q  <= cur_hp_d;
            cnt_q     <= cnt_d;
            square_q  <= square_d;
            stop_q    <= stop_d;
            pcap_q    <= pcap_d;
            pnote_q   <= pnote_d;
            poct_q    <= poct_d;
            pend_q    <= pend_d;
            pend_hp_q <= pend_hp_d;
        end
    end

    assign bus.playing = (state_q == ST_PLAY);
    assign bus.square  = square_q;
    assign bus.sample  = (state_q != ST_PLAY) ? '0 : (square_q ? AMP_P : AMP_N);

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen: start/invalid vector table, then
// multi-half-period sequences checked against a frequency-derived model.
module tb_note_tone_gen;
    import synth_pkg::*;

    localparam int     SW      = 24;
    localparam longint AMP     = 1048576;
    localparam real    TB_CLK  = 50.0e6;
    localparam int     BUDGET  = 20000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    note_tone_gen_if #(.SAMPLE_W(SW)) bus ();

    note_tone_gen #(.SAMPLE_W(SW), .AMPLITUDE(2**20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] note;
        logic [2:0] oct;
        logic       exp_play;
    } vec_t;

    typedef struct {
        int         at;
        logic       nv;
        logic       off;
        logic [3:0] note;
        logic [2:0] oct;
    } ev_t;

    vec_t vecs[$];
    ev_t  evq[$];

    // Reference model: pitch from the equal-tempered formula, A4 = 440 Hz.
    function automatic bit model_valid(input int n, input int o);
        return (n < 12) && (o < 7);
    endfunction

    function automatic int model_half(input int n, input int o);
        int  midi;
        real f;
        midi = (n < 3) ? 21 + n : 9 + n;
        f    = 440.0 * $pow(2.0, real'(midi - 69) / 12.0);
        return $rtoi(TB_CLK / (2.0 * f) + 0.5) >> o;
    endfunction

    function automatic ev_t mk_ev(input int at, input bit nv, input bit off,
                                  input int n, input int o);
        ev_t e;
        e.at   = at;
        e.nv   = nv;
        e.off  = off;
        e.note = 4'(n);
        e.oct  = 3'(o);
        return e;
    endfunction

    function automatic vec_t mk_vec(input int n, input int o, input bit p);
        vec_t v;
        v.note     = 4'(n);
        v.oct      = 3'(o);
        v.exp_play = p;
        return v;
    endfunction

    task automatic check(input string name, input longint actual, input longint expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input longint s, input bit sq, input bit pl);
        check({tag, ".sample"},  longint'(bus.sample), s);
        check({tag, ".square"},  longint'(bus.square), longint'(sq));
        check({tag, ".playing"}, longint'(bus.playing), longint'(pl));
    endtask

    // Drive one cycle of inputs from a negedge; returns at the following negedge.
    task automatic send(input bit nv, input bit off, input int n, input int o);
        bus.note       = 4'(n);
        bus.octave     = 3'(o);
        bus.note_valid = nv;
        bus.note_off   = off;
        @(negedge clk);
        bus.note_valid = 1'b0;
        bus.note_off   = 1'b0;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        bus.note_valid = 1'b0;
        bus.note_off   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_tone(input string tag, input int n, input int o);
        send(1'b1, 1'b0, n, o);
        @(negedge clk);
        check_outputs(tag, AMP, 1'b1, 1'b1);
    endtask

    // Count cycles until sample changes, injecting queued events on the way.
    task automatic run_half(input int budget, output int len);
        logic signed [SW-1:0] old;
        old = bus.sample;
        len = 0;
        while (len < budget) begin
            if (evq.size() > 0 && evq[0].at == len) begin
                bus.note       = evq[0].note;
                bus.octave     = evq[0].oct;
                bus.note_valid = evq[0].nv;
                bus.note_off   = evq[0].off;
                void'(evq.pop_front());
            end
            @(negedge clk);
            len++;
            bus.note_valid = 1'b0;
            bus.note_off   = 1'b0;
            if (bus.sample !== old) break;
        end
        evq.delete();
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int n0;
        int r;

        bus.note       = '0;
        bus.octave     = '0;
        bus.note_valid = 1'b0;
        bus.note_off   = 1'b0;

        apply_reset();
        check_outputs("reset", 0, 1'b0, 1'b0);

        vecs.push_back(mk_vec(0, 4, 1'b1));
        vecs.push_back(mk_vec(11, 6, 1'b1));
        vecs.push_back(mk_vec(3, 0, 1'b1));
        vecs.push_back(mk_vec(2, 6, 1'b1));
        vecs.push_back(mk_vec(12, 4, 1'b0));
        vecs.push_back(mk_vec(15, 2, 1'b0));
        vecs.push_back(mk_vec(0, 7, 1'b0));
        vecs.push_back(mk_vec(5, 7, 1'b0));
        for (int i = 0; i < 8; i++) begin
            int rn;
            int ro;
            rn = int'($urandom_range(0, 15));
            ro = int'($urandom_range(0, 7));
            vecs.push_back(mk_vec(rn, ro, model_valid(rn, ro)));
        end

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("tbl%0d(n=%0d,o=%0d)", i, vecs[i].note, vecs[i].oct);
            apply_reset();
            send(1'b1, 1'b0, int'(vecs[i].note), int'(vecs[i].oct));
            check({tag, ".load_playing"}, longint'(bus.playing), 0);
            @(negedge clk);
            check_outputs(tag, vecs[i].exp_play ? AMP : 0, vecs[i].exp_play, vecs[i].exp_play);
        end

        // note_off while in LOAD returns straight to IDLE.
        apply_reset();
        send(1'b1, 1'b0, 2, 6);
        send(1'b0, 1'b1, 0, 0);
        check_outputs("off_in_load", 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_outputs("off_in_load_hold", 0, 1'b0, 1'b0);

        // B6, a note_valid during LOAD is ignored; two pitch requests, last wins;
        // an octave-7 request then stops at the following boundary.
        apply_reset();
        send(1'b1, 1'b0, 2, 6);
        send(1'b1, 1'b0, 0, 6);
        check_outputs("seqA.start", AMP, 1'b1, 1'b1);
        evq.push_back(mk_ev(1000, 1'b1, 1'b0, 0, 6));
        evq.push_back(mk_ev(2000, 1'b1, 1'b0, 1, 6));
        run_half(BUDGET, len);
        check("seqA.half1_len", len, model_half(2, 6));
        check("seqA.half1_end", longint'(bus.sample), -AMP);
        evq.push_back(mk_ev(500, 1'b1, 1'b0, 3, 7));
        run_half(BUDGET, len);
        check("seqA.half2_len", len, model_half(1, 6));
        check_outputs("seqA.stopped", 0, 1'b0, 1'b0);
        run_half(300, len);
        check("seqA.quiet", len, 300);

        // Reset mid-half with a pending note armed.
        apply_reset();
        start_tone("seqE.start", 2, 6);
        evq.push_back(mk_ev(300, 1'b1, 1'b0, 0, 6));
        run_half(600, len);
        check("seqE.no_boundary", len, 600);
        reset = 1'b1;
        @(negedge clk);
        check_outputs("seqE.reset", 0, 1'b0, 1'b0);
        reset = 1'b0;

        // Fresh note after reset, then note_off at a random point.
        n0 = int'($urandom_range(0, 2));
        start_tone("seqB.start", n0, 6);
        r = int'($urandom_range(10, 5000));
        evq.push_back(mk_ev(r, 1'b0, 1'b1, 0, 0));
        run_half(BUDGET, len);
        check("seqB.half_len", len, model_half(n0, 6));
        check_outputs("seqB.stopped", 0, 1'b0, 1'b0);

        // Valid pending request, then an out-of-range note while playing.
        apply_reset();
        n0 = int'($urandom_range(0, 2));
        start_tone("seqC.start", n0, 6);
        r = int'($urandom_range(10, 3000));
        evq.push_back(mk_ev(r, 1'b1, 1'b0, int'($urandom_range(0, 11)), int'($urandom_range(0, 6))));
        evq.push_back(mk_ev(r + int'($urandom_range(5, 2000)), 1'b1, 1'b0,
                            12 + int'($urandom_range(0, 3)), int'($urandom_range(0, 6))));
        run_half(BUDGET, len);
        check("seqC.half_len", len, model_half(n0, 6));
        check_outputs("seqC.stopped", 0, 1'b0, 1'b0);

        // note_valid and note_off in the same cycle: stop wins, no pitch change.
        apply_reset();
        n0 = int'($urandom_range(0, 2));
        start_tone("seqD.start", n0, 6);
        r = int'($urandom_range(10, 5000));
        evq.push_back(mk_ev(r, 1'b1, 1'b1, int'($urandom_range(0, 11)), 6));
        run_half(BUDGET, len);
        check("seqD.half_len", len, model_half(n0, 6));
        check_outputs("seqD.stopped", 0, 1'b0, 1'b0);
        run_half(200, len);
        check("seqD.quiet", len, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
